// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// FSM state encoding, mcause codes and CSR operation encodings.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CSR,
      ST_TRAP_SAVE,
      ST_TRAP_JUMP,
      ST_RET
   } state_t;

   typedef enum logic [1:0] {
      LU_NONE  = 2'b00,
      LU_WRITE = 2'b01,
      LU_SET   = 2'b10,
      LU_CLEAR = 2'b11
   } luctrl_t;

   function automatic logic csr_known(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
         CSR_MEPC, CSR_MCAUSE, CSR_MIP: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/trap_controller_csr_alu.sv
// Combinational CSR read-modify-write unit.
// Ports: old_val (current CSR value), operand (rs1 or zimm), lu_ctrl
// (write/set/clear), rs1_is_x0 (source field is zero) -> new_val, write_en.
module csr_alu
   import trap_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] operand,
   input  logic [1:0]      lu_ctrl,
   input  logic            rs1_is_x0,
   output logic [XLEN-1:0] new_val,
   output logic            write_en
);

   always_comb begin
      new_val  = old_val;
      write_en = 1'b0;
      case (luctrl_t'(lu_ctrl))
         LU_WRITE: begin
            new_val  = operand;
            write_en = 1'b1;
         end
         // set/clear from x0 are pure reads
         LU_SET: begin
            new_val  = old_val | operand;
            write_en = ~rs1_is_x0;
         end
         LU_CLEAR: begin
            new_val  = old_val & ~operand;
            write_en = ~rs1_is_x0;
         end
         default: begin
            new_val  = old_val;
            write_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap and CSR sequencer. Owns the M-mode CSRs, sequences CSR
// read-modify-write, ecall/illegal/interrupt trap entry and mret.
// Ports: i_clk, i_rst_n (async active-low); decode inputs i_valid, i_ecall,
// i_mret, i_csrWrite, i_csrSrc, i_csrLUCtrl, i_csrAddr, operands i_rs1Data,
// i_zimm, i_rs1IsX0, i_pc, interrupt level i_irq; outputs o_ready, o_stall,
// o_flush, o_redirect, o_redirectPc, o_done, o_csrRdata.
//
// state        | meaning
// ST_IDLE      | waiting; accepts instruction or takes interrupt
// ST_CSR       | CSR op retires, old value on o_csrRdata
// ST_TRAP_SAVE | commit mepc/mcause, stack MIE into MPIE
// ST_TRAP_JUMP | redirect to mtvec
// ST_RET       | redirect to mepc, restore MIE from MPIE
module trap_controller
   import trap_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  logic            i_ecall,
   input  logic            i_mret,
   input  logic            i_csrWrite,
   input  logic            i_csrSrc,
   input  logic [1:0]      i_csrLUCtrl,
   input  logic [11:0]     i_csrAddr,
   input  logic [XLEN-1:0] i_rs1Data,
   input  logic [4:0]      i_zimm,
   input  logic            i_rs1IsX0,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_irq,
   output logic            o_ready,
   output logic            o_stall,
   output logic            o_flush,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirectPc,
   output logic            o_done,
   output logic [XLEN-1:0] o_csrRdata
);

   state_t state_q, state_d;

   logic            mie_q, mpie_q, meie_q;
   logic [XLEN-1:2] mtvec_q, mepc_q, pc_q;
   logic [XLEN-1:0] mscratch_q, mcause_q, cause_q, rdata_q;
   logic            irq_trap_q;

   logic            irq_pend, csr_ok, csr_go, trap_entry;
   logic [XLEN-1:0] entry_cause, csr_old, csr_new, operand;
   logic            csr_we;

   assign irq_pend = i_irq & mie_q & meie_q;
   assign csr_ok   = i_csrWrite & csr_known(i_csrAddr) & (i_csrLUCtrl != LU_NONE);
   assign operand  = i_csrSrc ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1Data;

   always_comb begin
      csr_old = '0;
      case (i_csrAddr)
         CSR_MSTATUS: begin
            csr_old[3] = mie_q;
            csr_old[7] = mpie_q;
         end
         CSR_MIE:      csr_old[11] = meie_q;
         CSR_MTVEC:    csr_old = {mtvec_q, 2'b00};
         CSR_MSCRATCH: csr_old = mscratch_q;
         CSR_MEPC:     csr_old = {mepc_q, 2'b00};
         CSR_MCAUSE:   csr_old = mcause_q;
         CSR_MIP:      csr_old[11] = i_irq;
         default:      csr_old = '0;
      endcase
   end

   csr_alu #(.XLEN(XLEN)) u_csr_alu (
      .old_val   (csr_old),
      .operand   (operand),
      .lu_ctrl   (i_csrLUCtrl),
      .rs1_is_x0 (i_rs1IsX0),
      .new_val   (csr_new),
      .write_en  (csr_we)
   );

   always_comb begin
      entry_cause = CAUSE_ILLEGAL;
      if (irq_pend)     entry_cause = CAUSE_MEI;
      else if (i_ecall) entry_cause = CAUSE_ECALL;
   end

   // Outputs are gated by i_rst_n so everything reads 0 while reset is held.
   always_comb begin
      state_d      = state_q;
      o_ready      = 1'b0;
      o_stall      = 1'b0;
      o_flush      = 1'b0;
      o_redirect   = 1'b0;
      o_redirectPc = '0;
      o_done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_rst_n) begin
               if (irq_pend) begin
                  state_d = ST_TRAP_SAVE;
               end else if (i_valid) begin
                  o_ready = 1'b1;
                  if (i_ecall)     state_d = ST_TRAP_SAVE;
                  else if (i_mret) state_d = ST_RET;
                  else if (csr_ok) state_d = ST_CSR;
                  else             state_d = ST_TRAP_SAVE;
               end
               o_stall = (state_d != ST_IDLE);
            end
         end
         ST_CSR: begin
            o_stall = 1'b1;
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_TRAP_SAVE: begin
            o_stall = 1'b1;
            o_flush = 1'b1;
            state_d = ST_TRAP_JUMP;
         end
         ST_TRAP_JUMP: begin
            o_stall      = 1'b1;
            o_flush      = 1'b1;
            o_redirect   = 1'b1;
            o_redirectPc = {mtvec_q, 2'b00};
            o_done       = ~irq_trap_q;
            state_d      = ST_IDLE;
         end
         ST_RET: begin
            o_stall      = 1'b1;
            o_flush      = 1'b1;
            o_redirect   = 1'b1;
            o_redirectPc = {mepc_q, 2'b00};
            o_done       = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign csr_go     = (state_q == ST_IDLE) && (state_d == ST_CSR);
   assign trap_entry = (state_q == ST_IDLE) && (state_d == ST_TRAP_SAVE);
   assign o_csrRdata = rdata_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cause_q    <= '0;
         pc_q       <= '0;
         irq_trap_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         if (trap_entry) begin
            cause_q    <= entry_cause;
            pc_q       <= i_pc[XLEN-1:2];
            irq_trap_q <= irq_pend;
         end
         if (csr_go) rdata_q <= csr_old;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET[XLEN-1:2];
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         if (csr_go && csr_we) begin
            case (i_csrAddr)
               CSR_MSTATUS: begin
                  mie_q  <= csr_new[3];
                  mpie_q <= csr_new[7];
               end
               CSR_MIE:      meie_q     <= csr_new[11];
               CSR_MTVEC:    mtvec_q    <= csr_new[XLEN-1:2];
               CSR_MSCRATCH: mscratch_q <= csr_new;
               CSR_MEPC:     mepc_q     <= csr_new[XLEN-1:2];
               CSR_MCAUSE:   mcause_q   <= csr_new;
               default: ;
            endcase
         end
         if (state_q == ST_TRAP_SAVE) begin
            mepc_q   <= pc_q;
            mcause_q <= cause_q;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end
         if (state_q == ST_RET) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end
      end
   end

endmodule
